// File: rtl/rebble_lcd_rx.sv
// rebble_lcd_rx: panel-side receiver for the Rebble memory-LCD interface.
// Define RX_FRAME_CRC_EN to build the per-frame CRC-16-CCITT of pixel data.
module rebble_lcd_rx #(
  parameter int LINES   = 148,
  parameter int COLUMNS = 205
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        xrst,
  input  logic        vst,
  input  logic        vck,
  input  logic        hst,
  input  logic        hck,
  input  logic        enb,
  input  logic [1:0]  red,
  input  logic [1:0]  green,
  input  logic [1:0]  blue,
  output logic        pix_valid,
  output logic [5:0]  pix_data,
  output logic [7:0]  pix_line,
  output logic [7:0]  pix_col,
  output logic        frame_active,
  output logic        frame_done,
  output logic [7:0]  frame_lines,
  output logic [3:0]  err,
  output logic [15:0] frame_crc
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARMED = 2'd1,
    FRAME = 2'd2
  } state_t;

  localparam int XR = 11;
  localparam int VS = 10;
  localparam int VC = 9;
  localparam int HS = 8;
  localparam int HC = 7;
  localparam int EN = 6;

  localparam logic [7:0] LAST_LINE = 8'(LINES - 1);
  localparam logic [7:0] NCOLS     = 8'(COLUMNS);

  logic [11:0] w_pins;
  logic [11:0] r_s1;
  logic [11:0] r_s2;
  logic [11:0] r_s3;

  logic       w_xrst_rise;
  logic       w_xrst_fall;
  logic       w_vst;
  logic       w_vck_rise;
  logic       w_vck_edge;
  logic       w_hst_rise;
  logic       w_hck_edge;
  logic [5:0] w_rgb;
  logic       w_unused;

  state_t     r_state;
  state_t     w_state_nxt;

  logic [7:0] r_line;
  logic [7:0] r_col;
  logic       r_hst_seen;
  logic [3:0] r_err;
  logic       r_frame_active;
  logic       r_frame_done;
  logic [7:0] r_frame_lines;
  logic       r_pix_valid;
  logic [5:0] r_pix_data;
  logic [7:0] r_pix_line;
  logic [7:0] r_pix_col;

  logic [7:0] w_line_nxt;
  logic [7:0] w_col_nxt;
  logic       w_seen_nxt;
  logic [3:0] w_err_nxt;
  logic       w_fact_nxt;
  logic [7:0] w_flines_nxt;
  logic [7:0] w_col_eff;
  logic       w_seen_eff;
  logic       w_start;
  logic       w_strobe;
  logic       w_done;

  assign w_pins = {xrst, vst, vck, hst, hck, enb,
                   red, green, blue};

  // Two synchronizer flops plus one history stage for edges
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
    end else begin
      r_s1 <= w_pins;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign w_xrst_rise = r_s2[XR] & ~r_s3[XR];
  assign w_xrst_fall = ~r_s2[XR] & r_s3[XR];
  assign w_vst       = r_s2[VS];
  assign w_vck_rise  = r_s2[VC] & ~r_s3[VC];
  assign w_vck_edge  = r_s2[VC] ^ r_s3[VC];
  assign w_hst_rise  = r_s2[HS] & ~r_s3[HS];
  assign w_hck_edge  = r_s2[HC] ^ r_s3[HC];
  assign w_rgb       = r_s2[5:0];

  // ENB and late RGB/VST history are synchronized but not decoded
  assign w_unused = ^{r_s2[EN], r_s3[EN], r_s3[VS], r_s3[5:0]};

  // State register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state, counters, error flags and strobe decisions
  always_comb begin
    w_state_nxt  = r_state;
    w_line_nxt   = r_line;
    w_col_nxt    = r_col;
    w_seen_nxt   = r_hst_seen;
    w_err_nxt    = r_err;
    w_fact_nxt   = r_frame_active;
    w_flines_nxt = r_frame_lines;
    w_col_eff    = r_col;
    w_seen_eff   = r_hst_seen;
    w_start      = 1'b0;
    w_strobe     = 1'b0;
    w_done       = 1'b0;
    if (w_xrst_fall) begin
      w_state_nxt = IDLE;
      w_fact_nxt  = 1'b0;
      if (r_state == FRAME) begin
        w_done       = 1'b1;
        w_flines_nxt = r_line + 8'd1;
        if (r_line < LAST_LINE) begin
          w_err_nxt[3] = 1'b1;
        end
      end
    end else begin
      unique case (r_state)
        IDLE: begin
          if (w_xrst_rise) begin
            w_state_nxt = ARMED;
            w_err_nxt   = '0;
            w_line_nxt  = '0;
            w_col_nxt   = '0;
          end
        end
        ARMED: begin
          if (w_vck_rise && w_vst) begin
            w_state_nxt = FRAME;
            w_line_nxt  = '0;
            w_col_nxt   = '0;
            w_seen_nxt  = 1'b0;
            w_fact_nxt  = 1'b1;
            w_start     = 1'b1;
          end
        end
        FRAME: begin
          if (w_vck_edge) begin
            if (r_line == LAST_LINE) begin
              w_err_nxt[1] = 1'b1;
            end else begin
              w_line_nxt = r_line + 8'd1;
            end
            w_col_nxt  = '0;
            w_seen_nxt = 1'b0;
            if (w_hck_edge) begin
              w_err_nxt[2] = 1'b1;
            end
          end else begin
            if (w_hst_rise) begin
              w_col_eff  = '0;
              w_seen_eff = 1'b1;
            end
            w_col_nxt  = w_col_eff;
            w_seen_nxt = w_seen_eff;
            if (w_hck_edge && w_seen_eff) begin
              if (w_col_eff < NCOLS) begin
                w_strobe  = 1'b1;
                w_col_nxt = w_col_eff + 8'd1;
              end else begin
                w_err_nxt[0] = 1'b1;
              end
            end
          end
        end
        default: begin
          w_state_nxt = IDLE;
        end
      endcase
    end
  end

  // Datapath registers and output strobes
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_line         <= '0;
      r_col          <= '0;
      r_hst_seen     <= 1'b0;
      r_err          <= '0;
      r_frame_active <= 1'b0;
      r_frame_done   <= 1'b0;
      r_frame_lines  <= '0;
      r_pix_valid    <= 1'b0;
      r_pix_data     <= '0;
      r_pix_line     <= '0;
      r_pix_col      <= '0;
    end else begin
      r_line         <= w_line_nxt;
      r_col          <= w_col_nxt;
      r_hst_seen     <= w_seen_nxt;
      r_err          <= w_err_nxt;
      r_frame_active <= w_fact_nxt;
      r_frame_done   <= w_done;
      r_frame_lines  <= w_flines_nxt;
      r_pix_valid    <= w_strobe;
      if (w_strobe) begin
        r_pix_data <= w_rgb;
        r_pix_line <= r_line;
        r_pix_col  <= w_col_eff;
      end
    end
  end

`ifdef RX_FRAME_CRC_EN
  logic [15:0] r_crc;
  logic [15:0] r_frame_crc;

  function automatic logic [15:0] f_crc_byte(
    input logic [15:0] c,
    input logic [7:0]  d
  );
    logic [15:0] v;
    v = c;
    for (int i = 7; i >= 0; i--) begin
      if (v[15] ^ d[i]) begin
        v = {v[14:0], 1'b0} ^ 16'h1021;
      end else begin
        v = {v[14:0], 1'b0};
      end
    end
    return v;
  endfunction

  // Running CRC over strobed pixels, latched at frame end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_crc       <= '0;
      r_frame_crc <= '0;
    end else begin
      if (w_start) begin
        r_crc <= 16'hFFFF;
      end else if (w_strobe) begin
        r_crc <= f_crc_byte(r_crc, {2'b00, w_rgb});
      end
      if (w_done) begin
        r_frame_crc <= r_crc;
      end
    end
  end

  assign frame_crc = r_frame_crc;
`else
  assign frame_crc = 16'h0000;
`endif

  assign pix_valid    = r_pix_valid;
  assign pix_data     = r_pix_data;
  assign pix_line     = r_pix_line;
  assign pix_col      = r_pix_col;
  assign frame_active = r_frame_active;
  assign frame_done   = r_frame_done;
  assign frame_lines  = r_frame_lines;
  assign err          = r_err;

endmodule

// File: tb/tb_rebble_lcd_rx.sv
// tb_rebble_lcd_rx: scoreboard bench for the memory-LCD receiver.
// Pixel and frame-end expectations are queued by stimulus, popped by monitors.
module tb_rebble_lcd_rx;

  localparam int LINES   = 148;
  localparam int COLUMNS = 205;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        xrst  = 1'b0;
  logic        vst   = 1'b0;
  logic        vck   = 1'b0;
  logic        hst   = 1'b0;
  logic        hck   = 1'b0;
  logic        enb   = 1'b0;
  logic [1:0]  red   = '0;
  logic [1:0]  green = '0;
  logic [1:0]  blue  = '0;
  logic        pix_valid;
  logic [5:0]  pix_data;
  logic [7:0]  pix_line;
  logic [7:0]  pix_col;
  logic        frame_active;
  logic        frame_done;
  logic [7:0]  frame_lines;
  logic [3:0]  err;
  logic [15:0] frame_crc;

  rebble_lcd_rx #(
    .LINES   (LINES),
    .COLUMNS (COLUMNS)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .xrst         (xrst),
    .vst          (vst),
    .vck          (vck),
    .hst          (hst),
    .hck          (hck),
    .enb          (enb),
    .red          (red),
    .green        (green),
    .blue         (blue),
    .pix_valid    (pix_valid),
    .pix_data     (pix_data),
    .pix_line     (pix_line),
    .pix_col      (pix_col),
    .frame_active (frame_active),
    .frame_done   (frame_done),
    .frame_lines  (frame_lines),
    .err          (err),
    .frame_crc    (frame_crc)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [7:0] line;
    logic [7:0] col;
    logic [5:0] data;
  } pix_t;

  typedef struct packed {
    logic [7:0]  lines;
    logic [3:0]  err;
    logic [15:0] crc;
  } fr_t;

  pix_t pix_q[$];
  fr_t  fr_q[$];

  int n_checks  = 0;
  int n_pass    = 0;
  int n_strobes = 0;

  int          m_line;
  int          m_col;
  logic        m_seen;
  logic [3:0]  m_err;
  logic [15:0] m_crc;

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h",
                  name, act, exp);
  endtask

  task automatic fail_now(input string name);
    n_checks++;
    $display("FAIL %s", name);
  endtask

  function automatic logic [15:0] crc_byte(input logic [15:0] c,
                                           input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = {r[14:0], 1'b0} ^ 16'h1021;
      else r = {r[14:0], 1'b0};
    end
    return r;
  endfunction

  // Pixel monitor
  always @(negedge clock) begin
    if (reset && pix_valid) begin
      pix_t e;
      n_strobes++;
      if (pix_q.size() == 0) begin
        fail_now("unexpected_pix_valid");
      end else begin
        e = pix_q.pop_front();
        chk("pixel_line_col_data",
            {10'd0, pix_line, pix_col, pix_data},
            {10'd0, e.line, e.col, e.data});
      end
    end
  end

  // Frame-end monitor
  always @(negedge clock) begin
    if (reset && frame_done) begin
      fr_t f;
      if (fr_q.size() == 0) begin
        fail_now("unexpected_frame_done");
      end else begin
        f = fr_q.pop_front();
        chk("frame_lines", {24'd0, frame_lines}, {24'd0, f.lines});
        chk("frame_err", {28'd0, err}, {28'd0, f.err});
        chk("frame_crc", {16'd0, frame_crc}, {16'd0, f.crc});
        chk("frame_active_low", {31'd0, frame_active}, 32'd0);
      end
    end
  end

  initial begin
    #1500000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "watchdog");
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_pix_valid"}, {31'd0, pix_valid}, 32'd0);
    chk({tag, "_pix_data"}, {26'd0, pix_data}, 32'd0);
    chk({tag, "_pix_line"}, {24'd0, pix_line}, 32'd0);
    chk({tag, "_pix_col"}, {24'd0, pix_col}, 32'd0);
    chk({tag, "_frame_active"}, {31'd0, frame_active}, 32'd0);
    chk({tag, "_frame_done"}, {31'd0, frame_done}, 32'd0);
    chk({tag, "_frame_lines"}, {24'd0, frame_lines}, 32'd0);
    chk({tag, "_err"}, {28'd0, err}, 32'd0);
    chk({tag, "_frame_crc"}, {16'd0, frame_crc}, 32'd0);
  endtask

  task automatic model_frame_start();
    m_line = 0;
    m_col  = 0;
    m_seen = 1'b0;
    m_crc  = 16'hFFFF;
  endtask

  task automatic start_frame();
    vst = 1'b0;
    vck = 1'b0;
    tick(4);
    xrst  = 1'b1;
    m_err = '0;
    tick(4);
    vst = 1'b1;
    tick(2);
    vck = 1'b1;
    tick(4);
    vst = 1'b0;
    tick(2);
    model_frame_start();
  endtask

  task automatic hst_pulse();
    hst = 1'b1;
    tick(3);
    hst = 1'b0;
    tick(3);
    m_col  = 0;
    m_seen = 1'b1;
  endtask

  task automatic hck_edge(input logic [5:0] d, input int gap);
    pix_t p;
    {red, green, blue} = d;
    hck = ~hck;
    if (m_seen) begin
      if (m_col < COLUMNS) begin
        p.line = 8'(m_line);
        p.col  = 8'(m_col);
        p.data = d;
        pix_q.push_back(p);
        m_crc = crc_byte(m_crc, {2'b00, d});
        m_col++;
      end else begin
        m_err[0] = 1'b1;
      end
    end
    tick(gap);
  endtask

  task automatic model_vck();
    if (m_line == LINES - 1) m_err[1] = 1'b1;
    else m_line++;
    m_col  = 0;
    m_seen = 1'b0;
  endtask

  task automatic vck_step();
    vck = ~vck;
    model_vck();
    tick(3);
  endtask

  task automatic collide(input logic [5:0] d);
    {red, green, blue} = d;
    vck = ~vck;
    hck = ~hck;
    model_vck();
    m_err[2] = 1'b1;
    tick(3);
  endtask

  task automatic end_frame();
    fr_t f;
    xrst = 1'b0;
    if (m_line + 1 < LINES) m_err[3] = 1'b1;
    f.lines = 8'(m_line + 1);
    f.err   = m_err;
`ifdef RX_FRAME_CRC_EN
    f.crc   = m_crc;
`else
    f.crc   = 16'h0000;
`endif
    fr_q.push_back(f);
    tick(6);
  endtask

  logic [5:0] d;
  int         saved;

  initial begin
    d = '0;
    tick(3);
    chk_all_zero("reset");
    reset = 1'b1;
    tick(3);

    // Full frame: 148 lines x 205 pixels
    enb = 1'b1;
    start_frame();
    chk("frame_active_high", {31'd0, frame_active}, 32'd1);
    for (int l = 0; l < LINES; l++) begin
      if (l > 0) vck_step();
      hst_pulse();
      for (int c = 0; c < COLUMNS; c++) begin
        hck_edge(d, 2);
        d = d + 6'd1;
      end
    end
    end_frame();
    chk("full_frame_strobes", n_strobes, 32'd30340);
    chk("last_pix_line", {24'd0, pix_line}, 32'd147);
    chk("last_pix_col", {24'd0, pix_col}, 32'd204);
    chk("full_frame_err", {28'd0, err}, 32'd0);
    enb = 1'b0;

    // Short frame with column overflow and collision
    start_frame();
    hst_pulse();
    for (int c = 0; c < COLUMNS + 2; c++) begin
      hck_edge(6'(c), 2);
    end
    tick(4);
    chk("col_overflow_err0", {31'd0, err[0]}, 32'd1);
    vck_step();
    hst_pulse();
    for (int c = 0; c < 5; c++) hck_edge(6'(c + 40), 3);
    collide(6'h11);
    tick(4);
    chk("collision_err2", {31'd0, err[2]}, 32'd1);
    hst_pulse();
    for (int c = 0; c < 3; c++) hck_edge(6'(c + 20), 3);
    for (int k = 0; k < 7; k++) vck_step();
    hst_pulse();
    hck_edge(6'h05, 3);
    hck_edge(6'h0A, 3);
    tick(4);
    end_frame();
    chk("short_err_sticky", {28'd0, err}, 32'hD);
    chk("idle_frame_active", {31'd0, frame_active}, 32'd0);

    // Re-arm clears sticky errors
    xrst = 1'b1;
    tick(5);
    chk("err_clear_on_arm", {28'd0, err}, 32'd0);

    // Line overflow: one VCK edge past the last line
    start_frame();
    for (int k = 0; k < LINES; k++) vck_step();
    tick(2);
    chk("line_overflow_err1", {31'd0, err[1]}, 32'd1);
    hst_pulse();
    hck_edge(6'h21, 3);
    hck_edge(6'h12, 3);
    tick(4);
    end_frame();

    // Reset in the middle of a frame
    start_frame();
    for (int k = 0; k < 50; k++) vck_step();
    hst_pulse();
    for (int c = 0; c < 3; c++) hck_edge(6'(c + 7), 3);
    tick(6);
    reset = 1'b0;
    xrst  = 1'b0;
    #1;
    chk_all_zero("midreset");
    tick(3);
    reset = 1'b1;
    tick(3);

    // Unarmed and unqualified VCK must not produce strobes
    saved = n_strobes;
    vck = 1'b0;
    tick(4);
    vck = 1'b1;
    tick(4);
    hst = 1'b1;
    tick(3);
    hst = 1'b0;
    tick(3);
    for (int c = 0; c < 4; c++) begin
      hck = ~hck;
      tick(3);
    end
    xrst = 1'b1;
    tick(4);
    vck = 1'b0;
    tick(3);
    vck = 1'b1;
    tick(4);
    hst = 1'b1;
    tick(3);
    hst = 1'b0;
    tick(3);
    for (int c = 0; c < 4; c++) begin
      hck = ~hck;
      tick(3);
    end
    tick(4);
    chk("no_strobe_unqualified", n_strobes, saved);

    // Qualified start: 4-pixel frame 3F 00 15 2A
    m_err = '0;
    vck = 1'b0;
    tick(3);
    vst = 1'b1;
    tick(2);
    vck = 1'b1;
    tick(4);
    vst = 1'b0;
    tick(2);
    model_frame_start();
    chk("qualified_frame_active", {31'd0, frame_active}, 32'd1);
    hst_pulse();
    hck_edge(6'h3F, 3);
    hck_edge(6'h00, 3);
    hck_edge(6'h15, 3);
    hck_edge(6'h2A, 3);
    tick(4);
    end_frame();
    chk("four_pix_strobes", n_strobes, saved + 4);

    tick(10);
    chk("pix_queue_drained", pix_q.size(), 32'd0);
    chk("frame_queue_drained", fr_q.size(), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
